// File: rtl/controller_if.sv
// Control-unit bus: instruction and datapath flags in, datapath/memory/port
// enables and ALU operation out.
interface controller_if;
    logic [15:0] Inst;
    logic [3:0]  ALUFlags;
    logic        RegWrite;
    logic        MemWrite;
    logic        ALUSrc;
    logic        PCSrc;
    logic        PortWrite;
    logic [3:0]  ALUControl;
    logic        IllegalOp;

    modport master (
        output Inst, ALUFlags,
        input  RegWrite, MemWrite, ALUSrc, PCSrc, PortWrite, ALUControl, IllegalOp
    );

    modport slave (
        input  Inst, ALUFlags,
        output RegWrite, MemWrite, ALUSrc, PCSrc, PortWrite, ALUControl, IllegalOp
    );
endinterface

// File: rtl/controller.sv
// Instruction decoder/sequencer: one-cycle BOOT after reset, single-cycle EXEC,
// and a second LOAD2 cycle for loads. Flags are registered from ALU ops only.
module controller (
    input  logic        clk,
    input  logic        rst_n,
    controller_if.slave bus
);

    typedef enum logic [1:0] {BOOT, EXEC, LOAD2} state_t;

    state_t      state, state_nx;
    logic [3:0]  flags_q;
    logic        illegal_q;
    logic [4:0]  opcode;
    logic        cond_true;
    logic        flag_load;
    logic        illegal_set;
    logic        reg_write, mem_write, alu_src, pc_src, port_write;
    logic [3:0]  alu_ctrl;

    assign opcode = bus.Inst[15:11];

    // Branch condition uses the registered flags {N,Z,C,V}.
    always_comb begin
        cond_true = 1'b0;
        case (bus.Inst[1:0])
            2'b00:   cond_true = flags_q[2];
            2'b01:   cond_true = ~flags_q[2];
            2'b10:   cond_true = flags_q[1];
            default: cond_true = flags_q[3];
        endcase
    end

    always_comb begin
        state_nx    = state;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        pc_src      = 1'b0;
        port_write  = 1'b0;
        alu_ctrl    = '0;
        flag_load   = 1'b0;
        illegal_set = 1'b0;
        case (state)
            BOOT: state_nx = EXEC;
            LOAD2: begin
                state_nx  = EXEC;
                reg_write = 1'b1;
                alu_src   = bus.Inst[0];
            end
            EXEC: begin
                if (!opcode[4]) begin
                    alu_ctrl  = opcode[3:0];
                    alu_src   = bus.Inst[0];
                    reg_write = 1'b1;
                    flag_load = 1'b1;
                end else begin
                    case (opcode)
                        5'b10000: begin pc_src = 1'b1; alu_src = bus.Inst[0]; end
                        5'b10001: begin pc_src = cond_true; alu_src = 1'b1; end
                        5'b10010: begin
                            pc_src    = 1'b1;
                            reg_write = 1'b1;
                            alu_src   = bus.Inst[0];
                        end
                        5'b10011: begin mem_write = 1'b1; alu_src = bus.Inst[0]; end
                        5'b10100: begin state_nx = LOAD2; alu_src = bus.Inst[0]; end
                        5'b10101: begin port_write = 1'b1; alu_src = bus.Inst[0]; end
                        5'b10110: begin reg_write = 1'b1; alu_src = bus.Inst[0]; end
                        5'b10111: ;
                        default:  illegal_set = 1'b1;
                    endcase
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (flag_load)   flags_q   <= bus.ALUFlags;
            if (illegal_set) illegal_q <= 1'b1;
        end
    end

    assign bus.RegWrite   = reg_write;
    assign bus.MemWrite   = mem_write;
    assign bus.ALUSrc     = alu_src;
    assign bus.PCSrc      = pc_src;
    assign bus.PortWrite  = port_write;
    assign bus.ALUControl = alu_ctrl;
    assign bus.IllegalOp  = illegal_q;

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- Inst  in  16  current instruction; opcode is Inst[15:11].
- ALUFlags  in  4  datapath flags {N,Z,C,V}, valid in the same cycle.
- RegWrite  out  1  register-file write enable.
- MemWrite  out  1  RAM write enable (STORE).
- ALUSrc  out  1  1 selects the immediate Inst[7:4] as Src2.
- PCSrc  out  1  1 loads the PC from Src2.
- PortWrite  out  1  output-port write enable (OUT).
- ALUControl  out  4  ALU operation code.
- IllegalOp  out  1  sticky flag for an undefined opcode.
REQ-002 All outputs except IllegalOp SHALL be combinational from state, Inst and the flag register.

Function
REQ-003 The FSM SHALL have three states: BOOT, EXEC and LOAD2.
REQ-004 BOOT SHALL force RegWrite, MemWrite, PortWrite and PCSrc to 0, and SHALL go to EXEC after 1 cycle.
REQ-005 EXEC SHALL go to LOAD2 when the opcode is 10100; otherwise it SHALL stay in EXEC.
REQ-006 LOAD2 SHALL return to EXEC unconditionally after 1 cycle.
REQ-007 ALU ops (Inst[15]=0): ALUControl=Inst[14:11], ALUSrc=Inst[0], RegWrite=1, all other enables 0.
REQ-008 For every non-ALU opcode, ALUControl SHALL be 4'h0.
REQ-009 A 4-bit flag register SHALL capture ALUFlags at the end of every EXEC cycle that executes an ALU op; it SHALL hold its value otherwise.
REQ-010 JMP (10000): PCSrc=1, ALUSrc=Inst[0], no writes.
REQ-011 BRcc (10001): ALUSrc=1; PCSrc=1 iff the condition on the registered flags holds.
- Inst[1:0] selects the condition: 00 Z, 01 !Z, 10 C, 11 N.
- A taken branch SHALL NOT update the flag register.
REQ-012 JAL (10010): PCSrc=1, ALUSrc=Inst[0], RegWrite=1.
REQ-013 STORE (10011): MemWrite=1, ALUSrc=Inst[0].
REQ-014 LOAD (10100), EXEC cycle: RegWrite=0, ALUSrc=Inst[0], PCSrc=0.
REQ-015 LOAD, LOAD2 cycle: RegWrite=1 (RAM data valid), ALUSrc=Inst[0], PCSrc=0; the same Inst SHALL be held by the PC stall.
REQ-016 OUT (10101): PortWrite=1, ALUSrc=Inst[0].
REQ-017 IN (10110): RegWrite=1, ALUSrc=Inst[0].
REQ-018 NOP (10111): all enables 0.
REQ-019 Any other opcode (11xxx, etc.) in EXEC SHALL drive all enables to 0 and SHALL set IllegalOp=1 on that edge.
REQ-020 IllegalOp SHALL stay set until reset.
REQ-021 Write enables SHALL never be asserted in the same cycle as IllegalOp is being set.
REQ-022 Back-to-back LOADs SHALL each take exactly 2 cycles.
REQ-023 A LOAD immediately after a BRcc SHALL use the flags registered before the LOAD.

Reset
REQ-024 On rst_n=0 the block SHALL immediately enter BOOT, clear the flag register to 4'h0 and clear IllegalOp, independent of clk.
REQ-025 While in reset, all enables SHALL be 0.
REQ-026 A reset asserted during LOAD2 SHALL abort the load with no RegWrite pulse.
REQ-027 The first rising edge after rst_n rises SHALL exit BOOT.

Verification
REQ-028 Reset release, Inst=ADD, ALUSrc bit set -> cycle 0 all enables 0 (BOOT); cycle 1 RegWrite=1, ALUSrc=1, ALUControl=Inst[14:11].
REQ-029 SUB giving ALUFlags=4'b0100, then BRcc cond 00 -> PCSrc=1; repeat with ALUFlags=4'b0000 -> PCSrc=0.
REQ-030 LOAD then ADD -> LOAD cycle 1 RegWrite=0; LOAD cycle 2 RegWrite=1; ADD executes in cycle 3; state sequence EXEC, LOAD2, EXEC.
REQ-031 rst_n pulled low mid-LOAD2 -> RegWrite=0 at once, flags=0, state BOOT.
REQ-032 Inst opcode 11111 -> enables 0 and IllegalOp=1 on the next edge; IllegalOp stays 1 through later valid instructions until rst_n=0.
REQ-033 STORE, OUT, IN, JAL in sequence -> exactly one of MemWrite / PortWrite / RegWrite / (RegWrite and PCSrc) asserted in each respective cycle.
